chaser_wb_multi: RTL and testbench

//  Parametrised Wishbone-controlled LED chaser: NLEDS-wide one-hot pattern stepped at a programmable rate.

---
 rtl/chaser_wb_multi.sv | 189 ++++++++++++++++++
 tb/tb_chaser_wb_multi.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/chaser_wb_multi.sv
// chaser_wb_multi: Wishbone-controlled one-hot LED chaser with bounce/wrap modes and pass counting.
// Optional done interrupt plus W1C clear of STATUS.done when CHASER_IRQ_EN is defined.
module chaser_wb_multi #(
  parameter int          NLEDS          = 8,
  parameter int          DIV_WIDTH      = 24,
  parameter int unsigned DEFAULT_PERIOD = 32'd16777215
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_cyc,
  input  logic             i_stb,
  input  logic             i_we,
  input  logic [1:0]       i_addr,
  input  logic [31:0]      i_data,
  output logic             o_stall,
  output logic             o_ack,
  output logic [31:0]      o_data,
  output logic [NLEDS-1:0] o_led,
  output logic             o_irq
);
  localparam int PW = $clog2(NLEDS);
  localparam logic [PW-1:0] POS_LAST = PW'(NLEDS - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  // Handshake: a transfer happens on a clock where i_stb=1 and o_stall=0; o_ack pulses exactly one
  // clock later with o_data valid. Only a START write while running is stalled.
  state_t               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [7:0]           rep_q, rep_d, left_q, left_d;
  logic [PW-1:0]        pos_q, pos_d;
  logic                 dir_up_q, dir_up_d;
  logic                 done_q, done_d;
  logic [DIV_WIDTH-1:0] period_q, period_d, div_q, div_d;
  logic [NLEDS-1:0]     led_q, led_d;
  logic                 ack_q, ack_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 busy, accept, wr, tick, pass_end, complete, w1c;
  logic                 unused_ok;

  assign busy      = (state_q == ST_RUN);
  assign o_stall   = busy && i_we && (i_addr == 2'd0) && i_data[31];
  assign accept    = i_stb && !o_stall;
  assign wr        = accept && i_we;
  assign tick      = busy && (div_q >= period_q);
  assign unused_ok = &{1'b0, i_cyc, i_data};

`ifdef CHASER_IRQ_EN
  assign w1c   = wr && (i_addr == 2'd2) && i_data[1];
  assign o_irq = done_q;
`else
  assign w1c   = 1'b0;
  assign o_irq = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    rep_d    = rep_q;
    left_d   = left_q;
    pos_d    = pos_q;
    dir_up_d = dir_up_q;
    period_d = period_q;
    pass_end = 1'b0;
    complete = 1'b0;
    div_d    = busy ? (tick ? '0 : div_q + DIV_WIDTH'(1)) : '0;

    if (tick) begin
      case (mode_q)
        2'd1: begin
          if (pos_q == POS_LAST) begin
            pass_end = 1'b1;
            pos_d    = '0;
          end else begin
            pos_d = pos_q + PW'(1);
          end
        end
        2'd2: begin
          if (pos_q == '0) begin
            pass_end = 1'b1;
            pos_d    = POS_LAST;
          end else begin
            pos_d = pos_q - PW'(1);
          end
        end
        default: begin
          // Bounce: a pass ends when leaving position 0 on the way down.
          if (dir_up_q) begin
            if (pos_q == POS_LAST) begin
              pos_d    = pos_q - PW'(1);
              dir_up_d = 1'b0;
            end else begin
              pos_d = pos_q + PW'(1);
            end
          end else if (pos_q == '0) begin
            pass_end = 1'b1;
            pos_d    = PW'(1);
            dir_up_d = 1'b1;
          end else begin
            pos_d = pos_q - PW'(1);
          end
        end
      endcase

      if (pass_end && (rep_q != 8'd0)) begin
        left_d = left_q - 8'd1;
        if (left_q == 8'd1) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
          pos_d    = pos_q;
        end
      end
    end

    if (wr && (i_addr == 2'd0)) begin
      if (i_data[31]) begin
        state_d  = ST_RUN;
        mode_d   = i_data[1:0];
        rep_d    = i_data[15:8];
        left_d   = i_data[15:8];
        div_d    = '0;
        pos_d    = (i_data[1:0] == 2'd2) ? POS_LAST : '0;
        dir_up_d = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end

    if (wr && (i_addr == 2'd1)) begin
      period_d = i_data[DIV_WIDTH-1:0];
    end

    // Completion outranks any clear landing on the same clock.
    done_d = done_q;
    if (w1c || (wr && (i_addr == 2'd0) && i_data[31])) begin
      done_d = 1'b0;
    end
    if (complete) begin
      done_d = 1'b1;
    end

    rdata_d = rdata_q;
    if (accept) begin
      case (i_addr)
        2'd0:    rdata_d = {busy, 15'd0, rep_q, 6'd0, mode_q};
        2'd1:    rdata_d = 32'(period_q);
        2'd2:    rdata_d = {8'd0, 8'(pos_q), left_q, 6'd0, done_q, busy};
        default: rdata_d = 32'(led_q);
      endcase
    end

    ack_d = accept;
    led_d = busy ? (NLEDS'(1) << pos_q) : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      mode_q   <= 2'd0;
      rep_q    <= 8'd0;
      left_q   <= 8'd0;
      pos_q    <= '0;
      dir_up_q <= 1'b1;
      done_q   <= 1'b0;
      period_q <= DIV_WIDTH'(DEFAULT_PERIOD);
      div_q    <= '0;
      led_q    <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      rep_q    <= rep_d;
      left_q   <= left_d;
      pos_q    <= pos_d;
      dir_up_q <= dir_up_d;
      done_q   <= done_d;
      period_q <= period_d;
      div_q    <= div_d;
      led_q    <= led_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
    end
  end

  assign o_ack  = ack_q;
  assign o_data = rdata_q;
  assign o_led  = led_q;
endmodule

// File: tb/tb_chaser_wb_multi.sv
// tb_chaser_wb_multi: directed and randomized checks of the LED chaser against a sequence-list model.
module tb_chaser_wb_multi;
  localparam int NL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cyc = 1'b0;
  logic          stb = 1'b0;
  logic          we = 1'b0;
  logic [1:0]    addr = 2'd0;
  logic [31:0]   wdata = 32'd0;
  logic          stall, ack, irq;
  logic [31:0]   rdata;
  logic [NL-1:0] led;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] exp_q[$];

  chaser_wb_multi #(.NLEDS(NL), .DIV_WIDTH(24), .DEFAULT_PERIOD(3)) dut (
    .i_clk(clk), .i_reset(rst), .i_cyc(cyc), .i_stb(stb), .i_we(we), .i_addr(addr),
    .i_data(wdata), .o_stall(stall), .o_ack(ack), .o_data(rdata), .o_led(led), .o_irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
  endtask

  // One bus transfer; waits out any stall (bounded) and checks the one-cycle ack.
  task automatic wb_xfer(input logic w, input logic [1:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output int stalls);
    stalls = 0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d;
    #1;
    while (stall && stalls < 400) begin
      @(negedge clk);
      #1;
      stalls++;
      chk("no_ack_while_stalled", 32'(ack), 32'd0);
    end
    chk("stall_bounded", 32'(stalls < 400), 32'd1);
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("ack_after_stb", 32'(ack), 32'd1);
    rd = rdata;
  endtask

  // Model: list of positions visited, each held for per+1 clocks, then dark.
  task automatic run_seq(input int mode, input int reps, input int per);
    logic [31:0] rd;
    int st;
    int pos_list[$];
    pos_list.delete();
    if (mode == 1) begin
      for (int r = 0; r < reps; r++) for (int k = 0; k < NL; k++) pos_list.push_back(k);
    end else if (mode == 2) begin
      for (int r = 0; r < reps; r++) for (int k = NL - 1; k >= 0; k--) pos_list.push_back(k);
    end else begin
      pos_list.push_back(0);
      for (int r = 0; r < reps; r++) begin
        for (int k = 1; k < NL; k++) pos_list.push_back(k);
        for (int k = NL - 2; k >= 0; k--) pos_list.push_back(k);
      end
    end
    exp_q.delete();
    foreach (pos_list[i]) repeat (per + 1) exp_q.push_back(32'd1 << pos_list[i]);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    wb_xfer(1'b1, 2'd1, 32'(per), rd, st);
    wb_xfer(1'b1, 2'd0, 32'h8000_0000 | (32'(reps) << 8) | 32'(mode), rd, st);
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      chk($sformatf("led_m%0d_r%0d_p%0d", mode, reps, per), 32'(led), exp_q.pop_front());
    end
    wb_xfer(1'b0, 2'd2, 32'd0, rd, st);
    chk("status_after_run", rd & 32'h0000_FFFF, 32'h0000_0002);
  endtask

  initial begin
    logic [31:0] rd;
    int st;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_data", rdata, 32'd0);
    wb_xfer(1'b0, 2'd1, 32'd0, rd, st);
    chk("rst_period", rd, 32'd3);
    wb_xfer(1'b0, 2'd2, 32'd0, rd, st);
    chk("rst_status", rd, 32'd0);
    wb_xfer(1'b0, 2'd3, 32'd0, rd, st);
    chk("rst_ledreg", rd, 32'd0);

    run_seq(0, 1, 3);
    run_seq(1, 2, 3);
    run_seq(2, 1, 3);

    // STATUS write must not clear done without the interrupt option.
`ifndef CHASER_IRQ_EN
    wb_xfer(1'b1, 2'd2, 32'h2, rd, st);
    wb_xfer(1'b0, 2'd2, 32'd0, rd, st);
    chk("status_wr_ignored", rd & 32'h3, 32'h2);
    chk("irq_tied_low", 32'(irq), 32'd0);
`endif

    // Restart while busy is held off until the run completes, then a stop mid-run.
    wb_xfer(1'b1, 2'd0, 32'h8000_0100, rd, st);
    wb_xfer(1'b1, 2'd0, 32'h8000_0100, rd, st);
    chk("restart_stalled", 32'(st > 20), 32'd1);
    repeat (6) @(posedge clk);
    wb_xfer(1'b1, 2'd0, 32'h0000_0000, rd, st);
    chk("stop_led_lag", 32'(led != '0), 32'd1);
    @(posedge clk);
    #1;
    chk("stop_led_dark", 32'(led), 32'd0);
    wb_xfer(1'b0, 2'd2, 32'd0, rd, st);
    chk("stop_status", rd & 32'h3, 32'h0);

    for (int n = 0; n < 6; n++) begin
      run_seq(int'($urandom_range(0, 3)), int'($urandom_range(1, 3)), int'($urandom_range(0, 4)));
    end

    // Endless repeat keeps running.
    wb_xfer(1'b1, 2'd1, 32'd0, rd, st);
    wb_xfer(1'b1, 2'd0, 32'h8000_0001, rd, st);
    repeat (20) @(posedge clk);
    wb_xfer(1'b0, 2'd2, 32'd0, rd, st);
    chk("endless_busy", rd & 32'h0000_FFFF, 32'h0000_0001);
    wb_xfer(1'b1, 2'd0, 32'd0, rd, st);

`ifdef CHASER_IRQ_EN
    run_seq(1, 1, 1);
    chk("irq_on_done", 32'(irq), 32'd1);
    wb_xfer(1'b1, 2'd2, 32'h2, rd, st);
    chk("irq_w1c", 32'(irq), 32'd0);
    // W1C lands on the completion tick: period 0, wrap-left, one pass completes 4 clocks after start.
    wb_xfer(1'b1, 2'd1, 32'd0, rd, st);
    wb_xfer(1'b1, 2'd0, 32'h8000_0101, rd, st);
    repeat (3) @(posedge clk);
    wb_xfer(1'b1, 2'd2, 32'h2, rd, st);
    repeat (2) @(posedge clk);
    #1;
    chk("irq_set_wins", 32'(irq), 32'd1);
`endif

    // Reset mid-run with a read in flight.
    wb_xfer(1'b1, 2'd1, 32'd7, rd, st);
    wb_xfer(1'b1, 2'd0, 32'h8000_0000, rd, st);
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; stb = 1'b1; we = 1'b0; addr = 2'd2;
    @(posedge clk);
    #1;
    chk("midrst_led", 32'(led), 32'd0);
    chk("midrst_no_ack", 32'(ack), 32'd0);
    @(negedge clk);
    rst = 1'b0; stb = 1'b0;
    #1;
    chk("midrst_no_ack2", 32'(ack), 32'd0);
    wb_xfer(1'b0, 2'd1, 32'd0, rd, st);
    chk("midrst_period", rd, 32'd3);
    wb_xfer(1'b0, 2'd2, 32'd0, rd, st);
    chk("midrst_status", rd, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
